soc_system_cpu_1_cpu_debug_ocimem_ctrl: RTL and testbench

- System-clock consumer of the debug-slave decoder outputs: takes `jdo` plus the `take_action_ocimem_*` strobes and drives reads and writes of the on-chip debug RAM.
- Returns read data on `MonDReg` and status on `monitor_ready` / `monitor_error`; these feed back into the debug-slave TCK shift chain.
- Sits between the debug-slave wrapper and the debug RAM.

---
 rtl/soc_system_cpu_1_cpu_debug_ocimem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_soc_system_cpu_1_cpu_debug_ocimem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_cpu_1_cpu_debug_ocimem_ctrl.sv
// Debug RAM access controller: decodes the OCI memory strobes from the debug slave
// into single-cycle RAM reads/writes and reports the result on MonDReg/monitor_* outputs.
module soc_system_cpu_1_cpu_debug_ocimem_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  // Only latencies of 1 and 2 are meaningful; anything else is treated as the nearest.
  localparam int unsigned LAT      = (RAM_LATENCY >= 2) ? 2 : 1;
  localparam logic        CNT_LAST = 1'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cnt_q, cnt_d;
  logic [ADDR_W-1:0]   areg_q, areg_d;
  logic [DATA_W-1:0]   dreg_q, dreg_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                re_d, we_d;

  logic                act_a, act_na, act_b, any_cmd;
  logic [ADDR_W-1:0]   jdo_addr;
  logic [ADDR_W-1:0]   areg_inc;
  logic                jdo_unused;

  // Strobes are masked during reset so no RAM access can leak out of a reset cycle.
  assign act_a    = take_action_ocimem_a    & ~reset;
  assign act_na   = take_no_action_ocimem_a & ~reset;
  assign act_b    = take_action_ocimem_b    & ~reset;
  assign any_cmd  = act_a | act_na | act_b;
  assign jdo_addr = jdo[26 +: ADDR_W];
  assign areg_inc = areg_q + 1'b1;

  assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    areg_d  = areg_q;
    dreg_d  = dreg_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    re_d    = 1'b0;
    we_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (act_a) begin
          areg_d = jdo_addr;
          if (jdo[24]) begin
            err_d = 1'b0;
          end
          if (jdo[25]) begin
            re_d    = 1'b1;
            addr_d  = jdo_addr;
            rdy_d   = 1'b0;
            cnt_d   = 1'b0;
            state_d = RD_WAIT;
          end
        end else if (act_na) begin
          areg_d  = areg_inc;
          re_d    = 1'b1;
          addr_d  = areg_inc;
          rdy_d   = 1'b0;
          cnt_d   = 1'b0;
          state_d = RD_WAIT;
        end else if (act_b) begin
          we_d    = 1'b1;
          addr_d  = areg_q;
          wdata_d = jdo[3 +: DATA_W];
          state_d = WR;
        end
      end

      RD_WAIT: begin
        if (any_cmd) begin
          err_d = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          dreg_d  = ram_rdata;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WR: begin
        if (any_cmd) begin
          err_d = 1'b1;
        end
        areg_d  = areg_inc;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 1'b0;
      areg_q  <= '0;
      dreg_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      areg_q  <= areg_d;
      dreg_q  <= dreg_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Address/data present the new value in the strobe cycle, then hold it while idle.
  assign ram_addr      = addr_d;
  assign ram_wdata     = wdata_d;
  assign ram_re        = re_d;
  assign ram_we        = we_d;
  assign MonDReg       = dreg_q;
  assign MonAReg       = areg_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_soc_system_cpu_1_cpu_debug_ocimem_ctrl.sv
// Directed bench for the OCI memory controller: RAM models behind a latency-1 and a
// latency-2 instance, with read/write expectations queued at stimulus time.
module tb_soc_system_cpu_1_cpu_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Latency-1 instance
  logic [37:0] jdo1;
  logic        a1, na1, b1;
  logic [7:0]  raddr1;
  logic [31:0] wdata1, rdata1, dreg1;
  logic        we1, re1, rdy1, err1, busy1;
  logic [7:0]  areg1;

  // Latency-2 instance
  logic [37:0] jdo2;
  logic        a2, na2, b2;
  logic [7:0]  raddr2;
  logic [31:0] wdata2, rdata2, dreg2;
  logic        we2, re2, rdy2, err2, busy2;
  logic [7:0]  areg2;

  soc_system_cpu_1_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .DATA_W(32), .RAM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .jdo(jdo1),
    .take_action_ocimem_a(a1), .take_no_action_ocimem_a(na1), .take_action_ocimem_b(b1),
    .ram_addr(raddr1), .ram_wdata(wdata1), .ram_we(we1), .ram_re(re1), .ram_rdata(rdata1),
    .MonDReg(dreg1), .MonAReg(areg1), .monitor_ready(rdy1), .monitor_error(err1), .busy(busy1)
  );

  soc_system_cpu_1_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .DATA_W(32), .RAM_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .jdo(jdo2),
    .take_action_ocimem_a(a2), .take_no_action_ocimem_a(na2), .take_action_ocimem_b(b2),
    .ram_addr(raddr2), .ram_wdata(wdata2), .ram_we(we2), .ram_re(re2), .ram_rdata(rdata2),
    .MonDReg(dreg2), .MonAReg(areg2), .monitor_ready(rdy2), .monitor_error(err2), .busy(busy2)
  );

  // RAM models
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] stage2;

  always @(posedge clk) begin
    if (we1) mem1[raddr1] <= wdata1;
    if (re1) rdata1 <= mem1[raddr1];
    if (we2) mem2[raddr2] <= wdata2;
    if (re2) stage2 <= mem2[raddr2];
    rdata2 <= stage2;
  end

  int n_cmp = 0;
  int n_err = 0;
  int re1_cnt = 0;
  int we1_cnt = 0;

  logic [31:0] rq1 [$];
  logic [31:0] rq2 [$];
  logic [39:0] wq1 [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [39:0] w;
    if (re1) re1_cnt++;
    if (we1) begin
      we1_cnt++;
      w = (wq1.size() > 0) ? wq1.pop_front() : 40'hxx_xxxxxxxx;
      check("wr_addr", {24'd0, raddr1}, {24'd0, w[39:32]});
      check("wr_data", wdata1, w[31:0]);
    end
    if (re1 || we1) check("re_we_excl", {31'd0, re1 & we1}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release1();
    a1 = 1'b0; na1 = 1'b0; b1 = 1'b0;
  endtask

  task automatic set_a1(input logic [7:0] addr, input logic rd, input logic clr);
    jdo1 = '0;
    jdo1[33:26] = addr;
    jdo1[25] = rd;
    jdo1[24] = clr;
    a1 = 1'b1;
  endtask

  task automatic set_b1(input logic [31:0] data);
    jdo1 = '0;
    jdo1[34:3] = data;
    b1 = 1'b1;
  endtask

  task automatic wait_ready1(output int cyc);
    cyc = 0;
    while (rdy1 !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_ready2(output int cyc);
    cyc = 0;
    while (rdy2 !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pop_read1(input string tag);
    logic [31:0] e;
    e = (rq1.size() > 0) ? rq1.pop_front() : 32'hxxxxxxxx;
    check(tag, dreg1, e);
  endtask

  initial begin
    int cyc;
    int re_snap;
    logic [31:0] e;

    reset = 1'b1;
    jdo1 = '0; a1 = 1'b0; na1 = 1'b0; b1 = 1'b0;
    jdo2 = '0; a2 = 1'b0; na2 = 1'b0; b2 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h0;
      mem2[i] = 32'h0;
    end
    mem1[8'h10] = 32'hDEADBEEF;
    mem1[8'h21] = 32'hA5A50021;
    mem1[8'h30] = 32'h12345678;
    mem2[8'h10] = 32'hDEADBEEF;

    tick();
    tick();
    check("rst_dreg", dreg1, 32'h0);
    check("rst_areg", {24'd0, areg1}, 32'h0);
    check("rst_ready", {31'd0, rdy1}, 32'h0);
    check("rst_error", {31'd0, err1}, 32'h0);
    check("rst_busy", {31'd0, busy1}, 32'h0);
    check("rst_ram_addr", {24'd0, raddr1}, 32'h0);
    reset = 1'b0;
    tick();

    // Load and read at 0x10
    set_a1(8'h10, 1'b1, 1'b0);
    rq1.push_back(32'hDEADBEEF);
    #1;
    check("ld_re", {31'd0, re1}, 32'd1);
    check("ld_raddr", {24'd0, raddr1}, 32'h10);
    check("ld_we", {31'd0, we1}, 32'd0);
    tick();
    release1();
    check("ld_busy", {31'd0, busy1}, 32'd1);
    check("ld_notready", {31'd0, rdy1}, 32'd0);
    wait_ready1(cyc);
    check("ld_latency", cyc, 32'd1);
    pop_read1("ld_dreg");
    check("ld_areg", {24'd0, areg1}, 32'h10);
    check("ld_idle", {31'd0, busy1}, 32'd0);
    check("ld_re_count", re1_cnt, 32'd1);

    // Write burst across the top of the address space
    set_a1(8'hFE, 1'b0, 1'b0);
    #1;
    check("wb_noread", {31'd0, re1}, 32'd0);
    tick();
    release1();
    check("wb_areg0", {24'd0, areg1}, 32'hFE);
    check("wb_idle0", {31'd0, busy1}, 32'd0);
    set_b1(32'h11111111);
    wq1.push_back({8'hFE, 32'h11111111});
    tick();
    release1();
    check("wb_busy", {31'd0, busy1}, 32'd1);
    tick();
    check("wb_areg1", {24'd0, areg1}, 32'hFF);
    set_b1(32'h22222222);
    wq1.push_back({8'hFF, 32'h22222222});
    tick();
    release1();
    tick();
    check("wb_areg_wrap", {24'd0, areg1}, 32'h00);
    check("wb_mem_fe", mem1[8'hFE], 32'h11111111);
    check("wb_mem_ff", mem1[8'hFF], 32'h22222222);
    check("wb_ready_kept", {31'd0, rdy1}, 32'd1);

    // Read-next
    set_a1(8'h20, 1'b0, 1'b0);
    tick();
    release1();
    na1 = 1'b1;
    rq1.push_back(32'hA5A50021);
    #1;
    check("rn_re", {31'd0, re1}, 32'd1);
    check("rn_raddr", {24'd0, raddr1}, 32'h21);
    tick();
    release1();
    check("rn_notready", {31'd0, rdy1}, 32'd0);
    wait_ready1(cyc);
    check("rn_latency", cyc, 32'd1);
    pop_read1("rn_dreg");
    check("rn_areg", {24'd0, areg1}, 32'h21);
    tick();
    tick();
    check("rn_addr_hold", {24'd0, raddr1}, 32'h21);

    // Write strobe during RD_WAIT is dropped and flags an error
    set_a1(8'h30, 1'b1, 1'b0);
    rq1.push_back(32'h12345678);
    tick();
    release1();
    set_b1(32'hBADBAD00);
    #1;
    check("col_rd_nowe", {31'd0, we1}, 32'd0);
    tick();
    release1();
    check("col_rd_ready", {31'd0, rdy1}, 32'd1);
    pop_read1("col_rd_dreg");
    check("col_rd_error", {31'd0, err1}, 32'd1);
    check("col_rd_areg", {24'd0, areg1}, 32'h30);
    tick();
    check("col_err_sticky", {31'd0, err1}, 32'd1);
    set_a1(8'h30, 1'b0, 1'b1);
    tick();
    release1();
    check("col_err_clear", {31'd0, err1}, 32'd0);

    // Read strobe during WR is dropped and flags an error
    set_b1(32'h0BAD0001);
    wq1.push_back({8'h30, 32'h0BAD0001});
    tick();
    release1();
    na1 = 1'b1;
    #1;
    check("col_wr_nore", {31'd0, re1}, 32'd0);
    tick();
    release1();
    check("col_wr_areg", {24'd0, areg1}, 32'h31);
    check("col_wr_error", {31'd0, err1}, 32'd1);

    // Simultaneous a and b in IDLE: a wins, b is ignored without error
    set_a1(8'h40, 1'b0, 1'b1);
    b1 = 1'b1;
    #1;
    check("pri_nowe", {31'd0, we1}, 32'd0);
    tick();
    release1();
    check("pri_areg", {24'd0, areg1}, 32'h40);
    check("pri_err_clear", {31'd0, err1}, 32'd0);
    check("pri_idle", {31'd0, busy1}, 32'd0);

    // Reset in the middle of a read
    set_a1(8'h10, 1'b1, 1'b0);
    tick();
    release1();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("mr_dreg", dreg1, 32'h0);
    check("mr_ready", {31'd0, rdy1}, 32'd0);
    check("mr_busy", {31'd0, busy1}, 32'd0);
    check("mr_areg", {24'd0, areg1}, 32'h0);
    re_snap = re1_cnt;
    tick();
    tick();
    tick();
    check("mr_no_re", re1_cnt, re_snap);
    check("mr_dreg_late", dreg1, 32'h0);

    // Latency-2 instance
    jdo2 = '0;
    jdo2[33:26] = 8'h10;
    jdo2[25] = 1'b1;
    a2 = 1'b1;
    rq2.push_back(32'hDEADBEEF);
    #1;
    check("l2_re", {31'd0, re2}, 32'd1);
    check("l2_raddr", {24'd0, raddr2}, 32'h10);
    tick();
    a2 = 1'b0;
    check("l2_busy", {31'd0, busy2}, 32'd1);
    wait_ready2(cyc);
    check("l2_latency", cyc, 32'd2);
    e = (rq2.size() > 0) ? rq2.pop_front() : 32'hxxxxxxxx;
    check("l2_dreg", dreg2, e);
    check("l2_areg", {24'd0, areg2}, 32'h10);

    tick();
    check("wq_drained", wq1.size(), 32'd0);
    check("rq_drained", rq1.size(), 32'd0);
    check("we_count", we1_cnt, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
